// File: rtl/display_arb_pkg.sv
// Shared definitions for the display arbiter and its round-robin picker.
package display_arb_pkg;

  // Number of requesters sharing the seven-segment display.
  localparam int NREQ = 4;

  // Value driven to the decoder while nobody owns the display.
  localparam int IDLE_ADDR = 0;

  // IDLE: display unowned. HOLD: one owner with the hold counter running.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// The search begins at the index just above start and wraps modulo N. This
// means start itself is the last index considered. Requesters whose excl bit
// is set are never chosen.
module rr_picker
  import display_arb_pkg::*;
#(
  parameter int N  = NREQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          vld
);

  logic [PW-1:0] idx;

  // Walk the requesters upward from start+1 and take the first eligible one.
  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(start) + k) % N);
      if (!vld && req[idx] && !excl[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares one seven-segment display among NREQ
// requesters. It guarantees each owner HOLD cycles under contention, unless
// the owner drops its request earlier. All outputs come straight from flops.
module display_arbiter #(
  parameter int AW   = 8,
  parameter int NREQ = display_arb_pkg::NREQ,
  parameter int HOLD = 12000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*AW-1:0]  data,
  output logic [NREQ-1:0]     gnt,
  output logic [AW-1:0]       addr,
  output logic                blank
);
  import display_arb_pkg::*;

  localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [AW-1:0]   addr_nx;
  logic            blank_nx;

  logic [NREQ-1:0] pick_excl;
  logic [NREQ-1:0] pick_win;
  logic            pick_vld;
  logic            owner_gone;
  logic            take;

  // The owner drops out this cycle if it is no longer requesting.
  assign owner_gone = (state == ST_HOLD) && ((req & gnt) == '0);

  // When the owner releases early, it is excluded from the next search.
  // On expiry it is still a candidate. Because the search starts just after
  // the owner, the owner is reached last and so has the lowest priority.
  assign pick_excl = owner_gone ? gnt : '0;

  rr_picker #(
    .N  (NREQ),
    .PW (PW)
  ) u_picker (
    .req   (req),
    .start (ptr),
    .excl  (pick_excl),
    .win   (pick_win),
    .vld   (pick_vld)
  );

  function automatic logic [PW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) oh2idx = PW'(i);
    end
  endfunction

  // State register: FSM, hold counter, last-granted pointer and all outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= PW'(NREQ - 1);
      gnt   <= '0;
      addr  <= AW'(IDLE_ADDR);
      blank <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
      gnt   <= gnt_nx;
      addr  <= addr_nx;
      blank <= blank_nx;
    end
  end

  // Next state: grant from IDLE, count down in HOLD, and re-arbitrate on
  // expiry or early release.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    take     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) take = 1'b1;
      end
      ST_HOLD: begin
        if (owner_gone || cnt == '0) begin
          if (pick_vld) begin
            take = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            gnt_nx   = '0;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
      end
    endcase
    if (take) begin
      state_nx = ST_HOLD;
      gnt_nx   = pick_win;
      cnt_nx   = CNT_LOAD;
      ptr_nx   = oh2idx(pick_win);
    end
  end

  // Output decode: forward the next owner's data, or the idle value.
  always_comb begin
    addr_nx = AW'(IDLE_ADDR);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_nx[i]) addr_nx = data[i*AW +: AW];
    end
    blank_nx = (state_nx == ST_IDLE);
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with HOLD=4. It uses directed scenarios plus
// a randomized run, checked against an ownership-level reference model.
module tb_display_arbiter;

  localparam int AW   = 8;
  localparam int NREQ = 4;
  localparam int HOLD = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*AW-1:0]  data = '0;
  logic [NREQ-1:0]     gnt;
  logic [AW-1:0]       addr;
  logic                blank;

  int checks = 0;
  int fails  = 0;

  // Reference model state: current owner (-1 = none), number of cycles it has
  // owned the display so far, and the last requester granted.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = NREQ - 1;
  logic [NREQ-1:0] e_gnt   = '0;
  logic [AW-1:0]   e_addr  = '0;
  logic            e_blank = 1'b1;

  display_arbiter #(
    .AW   (AW),
    .NREQ (NREQ),
    .HOLD (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .addr  (addr),
    .blank (blank)
  );

  always #5 clk = ~clk;

  // First requester after 'after' in circular order, skipping 'skip'.
  function automatic int rr_choose(input logic [NREQ-1:0] r, input int after, input int skip);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (after + k) % NREQ;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  // Advance the model using the inputs presented at this edge, then step the
  // clock. Afterwards, sample just past the edge.
  task automatic tick();
    int nxt;
    if (!reset) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = NREQ - 1;
    end else if (m_owner < 0) begin
      nxt = rr_choose(req, m_last, -1);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_held  = 1;
      end
    end else if (!req[m_owner]) begin
      nxt = rr_choose(req, m_owner, m_owner);
      m_owner = nxt;
      if (nxt >= 0) begin
        m_last = nxt;
        m_held = 1;
      end
    end else if (m_held >= HOLD) begin
      nxt = rr_choose(req, m_owner, -1);
      m_owner = nxt;
      m_last  = nxt;
      m_held  = 1;
    end else begin
      m_held++;
    end
    e_gnt   = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    e_addr  = (m_owner >= 0) ? data[m_owner*AW +: AW] : '0;
    e_blank = (m_owner < 0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [AW-1:0] v);
    data[i*AW +: AW] = v;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    data  = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || blank !== 1'b1 || addr !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d gnt=%b blank=%b addr=%h required gnt=0000 blank=1 addr=00", c, gnt, blank, addr);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || blank !== 1'b0 || addr !== data[7:0]) begin
      fails++;
      $display("FAIL reset_first_grant gnt=%b blank=%b addr=%h required gnt=0001 blank=0 addr=%h", gnt, blank, addr, data[7:0]);
    end
  endtask

  task automatic test_sole_requester();
    req = 4'b0000;
    pulse_reset();
    set_data(2, 8'h3A);
    req = 4'b0100;
    for (int c = 0; c < 21; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || addr !== 8'h3A || blank !== 1'b0 || gnt !== e_gnt) begin
        fails++;
        $display("FAIL sole_regrant cyc=%0d gnt=%b addr=%h blank=%b required gnt=0100 addr=3a blank=0", c, gnt, addr, blank);
      end
    end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] want;
    req = 4'b1111;
    pulse_reset();
    for (int g = 0; g < 5; g++) begin
      want = NREQ'(1 << (g % NREQ));
      for (int h = 0; h < HOLD; h++) begin
        tick();
        checks++;
        if (gnt !== want || gnt !== e_gnt || addr !== e_addr) begin
          fails++;
          $display("FAIL rotation slot=%0d cyc=%0d gnt=%b addr=%h required gnt=%b addr=%h", g, h, gnt, addr, want, e_addr);
        end
      end
    end
  endtask

  task automatic test_early_release();
    req = 4'b0000;
    pulse_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("FAIL release_owner gnt=%b required 0001", gnt);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || addr !== data[15:8] || gnt !== e_gnt) begin
      fails++;
      $display("FAIL release_handover gnt=%b addr=%h required gnt=0010 addr=%h", gnt, addr, data[15:8]);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || blank !== 1'b1 || addr !== 8'h00) begin
      fails++;
      $display("FAIL release_to_idle gnt=%b blank=%b addr=%h required gnt=0000 blank=1 addr=00", gnt, blank, addr);
    end
  endtask

  task automatic test_data_tracking();
    req = 4'b0000;
    pulse_reset();
    set_data(0, 8'h0F);
    req = 4'b0011;
    tick();
    checks++;
    if (addr !== 8'h0F || gnt !== 4'b0001) begin
      fails++;
      $display("FAIL track_initial addr=%h gnt=%b required addr=0f gnt=0001", addr, gnt);
    end
    set_data(0, 8'hF0);
    tick();
    checks++;
    if (addr !== 8'hF0 || gnt !== 4'b0001) begin
      fails++;
      $display("FAIL track_change addr=%h gnt=%b required addr=f0 gnt=0001", addr, gnt);
    end
  endtask

  task automatic test_reset_midhold();
    req = 4'b1111;
    pulse_reset();
    for (int c = 0; c < HOLD + 2; c++) tick();
    checks++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("FAIL midhold_owner gnt=%b required 0010", gnt);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || blank !== 1'b1 || addr !== 8'h00) begin
      fails++;
      $display("FAIL midhold_reset gnt=%b blank=%b addr=%h required gnt=0000 blank=1 addr=00", gnt, blank, addr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || addr !== data[7:0]) begin
      fails++;
      $display("FAIL midhold_restart gnt=%b addr=%h required gnt=0001 addr=%h", gnt, addr, data[7:0]);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      data  = $urandom;
      reset = ($urandom_range(0, 60) != 0);
      tick();
      checks++;
      if (gnt !== e_gnt || addr !== e_addr || blank !== e_blank || $countones(gnt) > 1) begin
        fails++;
        $display("FAIL random cyc=%0d gnt=%b addr=%h blank=%b required gnt=%b addr=%h blank=%b", c, gnt, addr, blank, e_gnt, e_addr, e_blank);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sole_requester();
    test_rotation();
    test_early_release();
    test_data_tracking();
    test_reset_midhold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter AW, default 8, width of one display value (two hex digits for the seven-segment decoder).
REQ-002 Parameter NREQ, default 4, number of requesters; fixed at 4 for this release.
REQ-003 Parameter HOLD, default 12000000, minimum clock cycles per grant under contention.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port req  input  NREQ  per-requester display request, level-sensitive.
REQ-007 Port data  input  NREQ*AW  packed values; requester i owns data[i*AW +: AW].
REQ-008 Port gnt  output  NREQ  one-hot grant; bit i high while requester i owns the display.
REQ-009 Port addr  output  AW  value forwarded to the decoder addr input.
REQ-010 Port blank  output  1  high when no requester owns the display.

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and HOLD (one owner, hold counter running).
REQ-012 All outputs SHALL be registered; a request sampled on cycle N SHALL produce gnt and addr on cycle N+1.
REQ-013 In IDLE with req != 0, the block SHALL grant the first requesting index after the last-granted pointer, searching upward modulo NREQ, and enter HOLD with counter = HOLD-1.
REQ-014 In IDLE with req == 0, it SHALL hold gnt=0, blank=1, and addr=0.
REQ-015 In HOLD, addr SHALL track data[owner] every cycle with one-cycle latency; blank=0.
REQ-016 In HOLD, the counter SHALL decrement by 1 per cycle and SHALL NOT wrap below 0.
REQ-017 At counter==0, the block SHALL re-arbitrate in the same cycle: search starts after the owner, owner has lowest priority, and the winner is granted next cycle with the counter reloaded.
REQ-018 A sole requester at expiry SHALL be re-granted to itself with no gap cycle (gnt stays high).
REQ-019 If the owner deasserts req in HOLD, the block SHALL release it that cycle: arbitrate among the others (owner excluded), or go to IDLE if none request.
REQ-020 The last-granted pointer SHALL update only on a new grant.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 Requests arriving mid-HOLD SHALL NOT pre-empt the owner before expiry.
REQ-023 The counter width SHALL be the minimum needed to hold HOLD-1; HOLD=1 SHALL give re-arbitration every cycle.

Reset
REQ-024 While reset is low at a rising edge, the next state SHALL be: IDLE, gnt=0, addr=0, blank=1, counter=0, pointer=NREQ-1 (requester 0 first), independent of req.
REQ-025 Reset asserted mid-HOLD SHALL drop gnt on the next cycle with no completion of the hold period.
REQ-026 The first grant SHALL be possible in the cycle after reset deasserts.

Structure
REQ-027 A shared package display_arb_pkg SHALL hold the state enumeration, NREQ, and the IDLE addr constant (0).
REQ-028 Round-robin selection SHALL be a combinational sub-module, rr_picker, taking req, a start pointer, and an exclude-owner mask, and returning a one-hot winner and a valid flag.
REQ-029 Hold counting and the FSM SHALL reside in display_arbiter; the block SHALL not instantiate the decoder.

Verification (HOLD=4 unless stated)
REQ-030 Hold reset low 3 cycles with req=4'b1111, then release -> gnt=0 and blank=1 during reset; gnt=4'b0001 and addr=data0 one cycle after release.
REQ-031 req=4'b0100 only, data2=8'h3A -> gnt=4'b0100 and addr=8'h3A from the next cycle, staying continuous for 20 cycles with no gap at expiries.
REQ-032 req=4'b1111 constant -> gnt sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
REQ-033 Owner 0 granted, req1 pending, owner drops req after 2 cycles -> gnt=4'b0010 on the next cycle.
REQ-034 Owner data changes 8'h0F to 8'hF0 mid-hold -> addr=8'hF0 exactly one cycle later, with gnt unchanged.
REQ-035 Reset pulsed low for 1 cycle mid-hold -> the next cycle shows gnt=0, blank=1, addr=0; re-grant restarts from requester 0.
